pwm_bank: RTL and testbench

Parametrised multi-channel PWM generator for the motor-drive path: one shared period counter drives `CHANNELS` independent duty-cycle comparators. Period and per-channel duty are programmable at run time through a simple write port. New values are staged in shadow registers and applied only at period boundaries, so outputs never glitch mid-period. It replaces the fixed-duty, per-channel-counter PWM generator and feeds the steering/speed selection logic.

---
 rtl/pwm_bank.sv | 141 ++++++++++++++
 tb/tb_pwm_bank.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_bank.sv
// ---------------------------------------------------------------------------
// pwm_bank
//
// Multi-channel PWM generator. One shared period counter feeds CHANNELS
// independent duty comparators. The host writes period and duty values into
// shadow registers. Those values are copied into the active registers only
// while idle or at the period wrap, so a running period never changes shape
// part-way through.
//
// Ports
//   clk           sole clock, rising edge
//   rst           asynchronous active-high reset
//   enable        1 = RUN (counting), 0 = IDLE (counter held at 0)
//   wr_en         write strobe for the shadow registers
//   wr_addr       0..CHANNELS-1 selects a duty shadow, CHANNELS selects the
//                 period shadow, anything else is ignored
//   wr_data       value written to the selected shadow register
//   pwm_out       registered PWM outputs, bit i = channel i
//   period_start  registered pulse on the first output cycle of each period
// ---------------------------------------------------------------------------
module pwm_bank #(
    parameter int unsigned CHANNELS       = 5,
    parameter int unsigned CNT_WIDTH      = 20,
    parameter int unsigned DEFAULT_PERIOD = 999999,
    parameter int unsigned DEFAULT_DUTY   = 0,
    parameter int unsigned ADDR_WIDTH     = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [CNT_WIDTH-1:0]  wr_data,
    output logic [CHANNELS-1:0]   pwm_out,
    output logic                  period_start
);

    localparam logic [CNT_WIDTH-1:0]  RST_PERIOD  = CNT_WIDTH'(DEFAULT_PERIOD);
    localparam logic [CNT_WIDTH-1:0]  RST_DUTY    = CNT_WIDTH'(DEFAULT_DUTY);
    localparam logic [ADDR_WIDTH-1:0] PERIOD_ADDR = ADDR_WIDTH'(CHANNELS);

    // The operating mode follows enable directly on every edge; there is no
    // registered mode, so the first RUN edge already sees cnt == 0.
    typedef enum logic {IDLE, RUN} mode_t;

    mode_t                 mode;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0]  per_s_q;
    logic [CNT_WIDTH-1:0]  per_a_q;
    logic                  load_active;
    logic [CHANNELS-1:0]   pwm_q, pwm_d;
    logic                  ps_q, ps_d;

    // ------------------------------------------------------------------
    // Counter next-state and active-register load control
    // ------------------------------------------------------------------
    always_comb begin
        mode        = enable ? RUN : IDLE;
        cnt_d       = '0;
        load_active = 1'b0;
        case (mode)
            IDLE: begin
                // Keep the active set tracking the shadows so that a
                // restart begins with the latest host values.
                cnt_d       = '0;
                load_active = 1'b1;
            end
            RUN: begin
                if (cnt_q == per_a_q) begin
                    cnt_d       = '0;
                    load_active = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                cnt_d       = '0;
                load_active = 1'b0;
            end
        endcase
        ps_d = enable && (cnt_q == '0);
    end

    // ------------------------------------------------------------------
    // Period shadow/active, counter and output flops
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            per_s_q <= RST_PERIOD;
            per_a_q <= RST_PERIOD;
            cnt_q   <= '0;
            pwm_q   <= '0;
            ps_q    <= 1'b0;
        end else begin
            if (wr_en && (wr_addr == PERIOD_ADDR)) begin
                per_s_q <= wr_data;
            end
            // Non-blocking copy takes the pre-write shadow value, so a write
            // that lands on the wrap edge is deferred by one period.
            if (load_active) begin
                per_a_q <= per_s_q;
            end
            cnt_q <= cnt_d;
            pwm_q <= pwm_d;
            ps_q  <= ps_d;
        end
    end

    // ------------------------------------------------------------------
    // Per-channel duty shadow/active registers and comparators
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
            logic [CNT_WIDTH-1:0] duty_s_q;
            logic [CNT_WIDTH-1:0] duty_a_q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    duty_s_q <= RST_DUTY;
                    duty_a_q <= RST_DUTY;
                end else begin
                    if (wr_en && (wr_addr == ADDR_WIDTH'(gi))) begin
                        duty_s_q <= wr_data;
                    end
                    if (load_active) begin
                        duty_a_q <= duty_s_q;
                    end
                end
            end

            // Duty above the period keeps the compare true for the whole
            // period, giving 100 % without a special case.
            assign pwm_d[gi] = enable && (cnt_q < duty_a_q);
        end
    endgenerate

    assign pwm_out      = pwm_q;
    assign period_start = ps_q;

endmodule

// File: tb/tb_pwm_bank.sv
// ---------------------------------------------------------------------------
// tb_pwm_bank
//
// Directed bench for pwm_bank (5 channels, 8-bit counter, reset period 3).
// Each clock step predicts the outputs for that edge into a queue from a
// behavioural model of the generator. The prediction is popped and compared
// after the edge. Directed checks on recorded output history confirm the
// expected waveforms: patterns, high-time counts and pulse counts.
// ---------------------------------------------------------------------------
module tb_pwm_bank;

    localparam int CH   = 5;
    localparam int CW   = 8;
    localparam int PADR = CH;

    logic          clk;
    logic          rst;
    logic          enable;
    logic          wr_en;
    logic [3:0]    wr_addr;
    logic [CW-1:0] wr_data;
    logic [CH-1:0] pwm_out;
    logic          period_start;

    pwm_bank #(
        .CHANNELS      (CH),
        .CNT_WIDTH     (CW),
        .DEFAULT_PERIOD(3),
        .DEFAULT_DUTY  (0),
        .ADDR_WIDTH    (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .pwm_out     (pwm_out),
        .period_start(period_start)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic [CH-1:0] pwm;
        logic          ps;
    } exp_t;

    exp_t          exp_q[$];
    logic [CH-1:0] hist[$];
    logic          ps_hist[$];

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    int m_ps, m_pa, m_cnt;
    int m_ds[CH];
    int m_da[CH];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        m_ps  = 3;
        m_pa  = 3;
        m_cnt = 0;
        for (int i = 0; i < CH; i++) begin
            m_ds[i] = 0;
            m_da[i] = 0;
        end
        exp_q.delete();
    endtask

    // One clock: predict, advance the model, clock the DUT, compare.
    task automatic tick();
        exp_t e;
        for (int i = 0; i < CH; i++) e.pwm[i] = enable && (m_cnt < m_da[i]);
        e.ps = enable && (m_cnt == 0);
        exp_q.push_back(e);
        if (!enable || (m_cnt == m_pa)) begin
            m_pa = m_ps;
            for (int i = 0; i < CH; i++) m_da[i] = m_ds[i];
            m_cnt = 0;
        end else begin
            m_cnt = m_cnt + 1;
        end
        if (wr_en) begin
            if (int'(wr_addr) < CH) m_ds[wr_addr] = int'(wr_data);
            else if (int'(wr_addr) == PADR) m_ps = int'(wr_data);
        end
        @(posedge clk);
        @(negedge clk);
        e = exp_q.pop_front();
        check("pwm_out", 32'(pwm_out), 32'(e.pwm));
        check("period_start", 32'(period_start), 32'(e.ps));
        $display("t=%0t en=%0b wr=%0b a=%0d d=%0d pwm=%b ps=%b", $time, enable, wr_en,
                 wr_addr, wr_data, pwm_out, period_start);
        hist.push_back(pwm_out);
        ps_hist.push_back(period_start);
    endtask

    task automatic wr(input int a, input int d);
        wr_en   = 1'b1;
        wr_addr = a[3:0];
        wr_data = d[CW-1:0];
        tick();
        wr_en   = 1'b0;
    endtask

    function automatic int ones(input int ch, input int from, input int n);
        int c = 0;
        for (int k = 0; k < n; k++) c += int'(hist[from+k][ch]);
        return c;
    endfunction

    function automatic int ps_ones(input int from, input int n);
        int c = 0;
        for (int k = 0; k < n; k++) c += int'(ps_hist[from+k]);
        return c;
    endfunction

    function automatic int any_pwm(input int from, input int n);
        int c = 0;
        for (int k = 0; k < n; k++) c += (hist[from+k] != '0) ? 1 : 0;
        return c;
    endfunction

    function automatic logic [3:0] pat(input int ch, input int from);
        logic [3:0] r;
        for (int k = 0; k < 4; k++) r[3-k] = hist[from+k][ch];
        return r;
    endfunction

    initial begin
        rst     = 1'b1;
        enable  = 1'b0;
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        model_reset();
        repeat (2) @(negedge clk);
        check("reset_pwm", 32'(pwm_out), 32'h0);
        check("reset_ps", 32'(period_start), 32'h0);

        // Reset values: default period 3, duty 0
        rst    = 1'b0;
        enable = 1'b1;
        hist.delete(); ps_hist.delete();
        repeat (8) tick();
        check("default_ps_count", 32'(ps_ones(0, 8)), 32'd2);
        check("default_ps_first", 32'(ps_hist[0]), 32'd1);
        check("default_ps_second", 32'(ps_hist[4]), 32'd1);
        check("default_pwm_low", 32'(any_pwm(0, 8)), 32'd0);

        // Basic duty, written while idle; invalid addresses must be ignored
        enable = 1'b0;
        tick();
        wr(PADR, 3);
        wr(0, 1);
        wr(1, 2);
        wr(2, 4);
        wr(6, 200);
        wr(15, 0);
        tick();
        enable = 1'b1;
        hist.delete(); ps_hist.delete();
        repeat (8) tick();
        check("basic_ch0", 32'(pat(0, 0)), 32'b1000);
        check("basic_ch1", 32'(pat(1, 0)), 32'b1100);
        check("basic_ch2", 32'(pat(2, 0)), 32'b1111);
        check("basic_ch3", 32'(pat(3, 0)), 32'b0000);
        check("basic_ch0_p2", 32'(pat(0, 4)), 32'b1000);
        check("basic_ch1_p2", 32'(pat(1, 4)), 32'b1100);
        check("basic_ps", 32'({ps_hist[0], ps_hist[1], ps_hist[4]}), 32'b101);

        // Period 0: one-cycle period, duty 0 low, duty >= 1 high
        enable = 1'b0;
        tick();
        wr(PADR, 0);
        wr(0, 0);
        wr(1, 1);
        tick();
        enable = 1'b1;
        hist.delete(); ps_hist.delete();
        repeat (5) tick();
        check("p0_ps_all", 32'(ps_ones(0, 5)), 32'd5);
        check("p0_ch0_low", 32'(ones(0, 0, 5)), 32'd0);
        check("p0_ch1_high", 32'(ones(1, 0, 5)), 32'd5);
        check("p0_ch2_high", 32'(ones(2, 0, 5)), 32'd5);

        // Period 9, duty 3 -> 7 written at cnt = 4
        enable = 1'b0;
        tick();
        wr(PADR, 9);
        wr(0, 3);
        tick();
        enable = 1'b1;
        hist.delete(); ps_hist.delete();
        repeat (4) tick();
        wr(0, 7);
        repeat (15) tick();
        check("mid_p1_high", 32'(ones(0, 0, 10)), 32'd3);
        check("mid_p2_high", 32'(ones(0, 10, 10)), 32'd7);

        // Same update landing on the wrap edge (cnt = 9)
        enable = 1'b0;
        tick();
        wr(0, 3);
        tick();
        enable = 1'b1;
        hist.delete(); ps_hist.delete();
        repeat (9) tick();
        wr(0, 7);
        repeat (20) tick();
        check("wrap_p1_high", 32'(ones(0, 0, 10)), 32'd3);
        check("wrap_p2_high", 32'(ones(0, 10, 10)), 32'd3);
        check("wrap_p3_high", 32'(ones(0, 20, 10)), 32'd7);

        // Enable drop at cnt = 5, then re-enable
        repeat (5) tick();
        enable = 1'b0;
        tick();
        check("drop_pwm", 32'(pwm_out), 32'h0);
        check("drop_ps", 32'(period_start), 32'h0);
        enable = 1'b1;
        tick();
        check("reen_ps", 32'(period_start), 32'd1);
        check("reen_pwm", 32'(pwm_out), 32'b00111);

        // Async reset between edges while ch0 is high
        tick();
        check("pre_rst_ch0", 32'(pwm_out[0]), 32'd1);
        #1 rst = 1'b1;
        #1;
        check("async_rst_pwm", 32'(pwm_out), 32'h0);
        check("async_rst_ps", 32'(period_start), 32'h0);
        model_reset();
        #1 rst = 1'b0;
        hist.delete(); ps_hist.delete();
        repeat (8) tick();
        check("post_rst_ps_count", 32'(ps_ones(0, 8)), 32'd2);
        check("post_rst_ps_phase", 32'({ps_hist[0], ps_hist[4]}), 32'b11);
        check("post_rst_pwm_low", 32'(any_pwm(0, 8)), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
